// File: rtl/ex_mem_reg_pkg.sv
// Shared defines for the EX/MEM pipeline register: bus widths, stall and
// enable constants, the NOP aluop code and the EX->MEM payload struct.
package ex_mem_reg_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned RegAddrBus   = 5;
  localparam int unsigned AluOpBus     = 8;
  localparam int unsigned DoubleRegBus = 64;
  localparam int unsigned StallBus     = 6;
  localparam int unsigned CntBus       = 2;

  // Stall vector bit positions
  localparam int unsigned StallEx  = 3;
  localparam int unsigned StallMem = 4;

  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;
  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;

  localparam logic [AluOpBus-1:0] AluOpNop = 8'h00;

  // Everything handed from EX to MEM
  typedef struct packed {
    logic [RegAddrBus-1:0] wd;
    logic                  wreg;
    logic [RegBus-1:0]     wdata;
    logic [RegBus-1:0]     hi;
    logic [RegBus-1:0]     lo;
    logic                  whilo;
    logic [AluOpBus-1:0]   aluop;
    logic [RegBus-1:0]     mem_addr;
    logic [RegBus-1:0]     reg2;
  } mem_payload_t;

  // Bubble / reset payload: no register write, no HI/LO write, NOP op
  function automatic mem_payload_t nop_payload();
    mem_payload_t p;
    p       = '0;
    p.wreg  = ~WriteEnable;
    p.whilo = ~WriteEnable;
    p.aluop = AluOpNop;
    return p;
  endfunction

  // Accumulate step count only ever holds 0 or 1; 2 and 3 collapse to 0
  function automatic logic [CntBus-1:0] clamp_cnt(input logic [CntBus-1:0] c);
    return (c == CntBus'(1)) ? CntBus'(1) : CntBus'(0);
  endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register.
// Latches the EX stage results for the MEM stage with one cycle of latency.
// Priority: rst > flush > bubble (EX stopped, MEM running) > advance > hold.
// Optional accumulate feedback path (hilo_o/cnt_o) enabled by macro HILO_ACC_EN;
// without it hilo_o/cnt_o are constant 0 and hilo_i/cnt_i are ignored.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall[5:0], flush   pipeline control
//   ex_*                EX stage results (dest reg, HI/LO, load/store info)
//   hilo_i, cnt_i       accumulate partial product / step count from EX
//   mem_*               registered copies for MEM
//   hilo_o, cnt_o       held partial product / step count back to EX
module ex_mem_reg
  import ex_mem_reg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic                    flush,
  input  logic [RegAddrBus-1:0]   ex_wd,
  input  logic                    ex_wreg,
  input  logic [RegBus-1:0]       ex_wdata,
  input  logic [RegBus-1:0]       ex_hi,
  input  logic [RegBus-1:0]       ex_lo,
  input  logic                    ex_whilo,
  input  logic [AluOpBus-1:0]     ex_aluop,
  input  logic [RegBus-1:0]       ex_mem_addr,
  input  logic [RegBus-1:0]       ex_reg2,
  input  logic [DoubleRegBus-1:0] hilo_i,
  input  logic [CntBus-1:0]       cnt_i,
  output logic [RegAddrBus-1:0]   mem_wd,
  output logic                    mem_wreg,
  output logic [RegBus-1:0]       mem_wdata,
  output logic [RegBus-1:0]       mem_hi,
  output logic [RegBus-1:0]       mem_lo,
  output logic                    mem_whilo,
  output logic [AluOpBus-1:0]     mem_aluop,
  output logic [RegBus-1:0]       mem_mem_addr,
  output logic [RegBus-1:0]       mem_reg2,
  output logic [DoubleRegBus-1:0] hilo_o,
  output logic [CntBus-1:0]       cnt_o
);

  mem_payload_t ex_pay;
  mem_payload_t pay_d, pay_q;
  logic         bubble;
  logic         advance;
  logic         unused_stall;

  assign ex_pay = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, hi: ex_hi,
                    lo: ex_lo, whilo: ex_whilo, aluop: ex_aluop,
                    mem_addr: ex_mem_addr, reg2: ex_reg2};

  // EX stopped while MEM keeps going inserts a bubble; EX running always
  // advances, so the contradictory EX-running/MEM-stopped code advances too.
  assign bubble  = (stall[StallEx] == Stop) && (stall[StallMem] == NoStop);
  assign advance = (stall[StallEx] == NoStop);

  assign unused_stall = ^{stall[StallBus-1:StallMem+1], stall[StallEx-1:0]};

  // Payload next state
  always_comb begin
    pay_d = pay_q;
    if (flush) begin
      pay_d = nop_payload();
    end else if (bubble) begin
      pay_d = nop_payload();
    end else if (advance) begin
      pay_d = ex_pay;
    end
  end

  // Payload register
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pay_q <= nop_payload();
    end else begin
      pay_q <= pay_d;
    end
  end

  assign mem_wd       = pay_q.wd;
  assign mem_wreg     = pay_q.wreg;
  assign mem_wdata    = pay_q.wdata;
  assign mem_hi       = pay_q.hi;
  assign mem_lo       = pay_q.lo;
  assign mem_whilo    = pay_q.whilo;
  assign mem_aluop    = pay_q.aluop;
  assign mem_mem_addr = pay_q.mem_addr;
  assign mem_reg2     = pay_q.reg2;

`ifdef HILO_ACC_EN
  logic [DoubleRegBus-1:0] hilo_d, hilo_q;
  logic [CntBus-1:0]       cnt_d, cnt_q;

  // Accumulate state: captured on a bubble, cleared on advance or flush
  always_comb begin
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    if (flush) begin
      hilo_d = '0;
      cnt_d  = '0;
    end else if (bubble) begin
      hilo_d = hilo_i;
      cnt_d  = clamp_cnt(cnt_i);
    end else if (advance) begin
      hilo_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hilo_q <= '0;
      cnt_q  <= '0;
    end else begin
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hilo_o = hilo_q;
  assign cnt_o  = cnt_q;
`else
  logic unused_acc;

  assign unused_acc = ^{hilo_i, cnt_i};
  assign hilo_o     = '0;
  assign cnt_o      = '0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Testbench for ex_mem_reg: directed vector table, a synchronous-reset pulse
// sequence and a randomized run against a behavioural model.
module tb_ex_mem_reg;

`ifdef HILO_ACC_EN
  localparam bit AccEn = 1'b1;
`else
  localparam bit AccEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic        ex_whilo;
  logic [7:0]  ex_aluop;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic        mem_whilo;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed vector: control + key EX inputs, expected key outputs.
  // exp_hilo/exp_cnt are the accumulate-enabled values; masked when disabled.
  typedef struct {
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [4:0]  exp_wd;
    logic        exp_wreg;
    logic [31:0] exp_wdata;
    logic        exp_whilo;
    logic [31:0] exp_hi;
    logic [63:0] exp_hilo;
    logic [1:0]  exp_cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic f, input logic [5:0] s,
    input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
    input logic wh, input logic [31:0] hi, input logic [63:0] hl, input logic [1:0] c,
    input logic [4:0] e_wd, input logic e_wr, input logic [31:0] e_wdat,
    input logic e_wh, input logic [31:0] e_hi, input logic [63:0] e_hl, input logic [1:0] e_c);
    vec_t v;
    v.rst = r; v.flush = f; v.stall = s; v.wd = wd; v.wreg = wr; v.wdata = wdat;
    v.whilo = wh; v.hi = hi; v.hilo = hl; v.cnt = c;
    v.exp_wd = e_wd; v.exp_wreg = e_wr; v.exp_wdata = e_wdat; v.exp_whilo = e_wh;
    v.exp_hi = e_hi; v.exp_hilo = e_hl; v.exp_cnt = e_c;
    return v;
  endfunction

  // Behavioural model of the output state
  logic [4:0]  m_wd;
  logic        m_wreg, m_whilo;
  logic [31:0] m_wdata, m_hi, m_lo, m_addr, m_reg2;
  logic [7:0]  m_aluop;
  logic [63:0] m_hilo;
  logic [1:0]  m_cnt;

  task automatic model_zero();
    m_wd = '0; m_wreg = 1'b0; m_wdata = '0; m_hi = '0; m_lo = '0;
    m_whilo = 1'b0; m_aluop = '0; m_addr = '0; m_reg2 = '0;
  endtask

  task automatic model_step();
    if (rst || flush) begin
      model_zero();
      m_hilo = '0; m_cnt = '0;
    end else if (stall[3] && !stall[4]) begin
      model_zero();
      if (AccEn) begin
        m_hilo = hilo_i;
        m_cnt  = (cnt_i == 2'd1) ? 2'd1 : 2'd0;
      end
    end else if (!stall[3]) begin
      m_wd = ex_wd; m_wreg = ex_wreg; m_wdata = ex_wdata; m_hi = ex_hi;
      m_lo = ex_lo; m_whilo = ex_whilo; m_aluop = ex_aluop;
      m_addr = ex_mem_addr; m_reg2 = ex_reg2;
      m_hilo = '0; m_cnt = '0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wd"},    64'(mem_wd),       64'(m_wd));
    chk({tag, ".wreg"},  64'(mem_wreg),     64'(m_wreg));
    chk({tag, ".wdata"}, 64'(mem_wdata),    64'(m_wdata));
    chk({tag, ".hi"},    64'(mem_hi),       64'(m_hi));
    chk({tag, ".lo"},    64'(mem_lo),       64'(m_lo));
    chk({tag, ".whilo"}, 64'(mem_whilo),    64'(m_whilo));
    chk({tag, ".aluop"}, 64'(mem_aluop),    64'(m_aluop));
    chk({tag, ".addr"},  64'(mem_mem_addr), 64'(m_addr));
    chk({tag, ".reg2"},  64'(mem_reg2),     64'(m_reg2));
    chk({tag, ".hilo"},  hilo_o,            m_hilo);
    chk({tag, ".cnt"},   64'(cnt_o),        64'(m_cnt));
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0;
    ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_hi = '0; ex_lo = '0;
    ex_whilo = 1'b0; ex_aluop = '0; ex_mem_addr = '0; ex_reg2 = '0;
    hilo_i = '0; cnt_i = '0;

    //           rst   flush stall       wd  wr wdata         wh hi            hilo_i                 cnt    e_wd e_wr e_wdata      e_wh e_hi          e_hilo                 e_cnt
    vecs.push_back(mk(1, 0, 6'b000000, 5'd9, 1, 32'h1111_1111, 1, 32'h2222_2222, 64'h5,                 2'd1, 5'd0, 0, 32'h0,        0, 32'h0,        64'h0,                 2'd0)); // reset
    vecs.push_back(mk(0, 0, 6'b000000, 5'd5, 1, 32'h1234_5678, 0, 32'h0,        64'h77,                2'd1, 5'd5, 1, 32'h1234_5678, 0, 32'h0,        64'h0,                 2'd0)); // advance
    vecs.push_back(mk(0, 0, 6'b001111, 5'd7, 1, 32'h0000_0099, 0, 32'h0,        64'h0000_0001_FFFF_FFFE, 2'd1, 5'd0, 0, 32'h0,     0, 32'h0,        64'h0000_0001_FFFF_FFFE, 2'd1)); // bubble
    vecs.push_back(mk(0, 0, 6'b000000, 5'd7, 1, 32'h0000_0099, 0, 32'h0,        64'h5,                 2'd1, 5'd7, 1, 32'h0000_0099, 0, 32'h0,        64'h0,                 2'd0)); // advance clears acc
    vecs.push_back(mk(0, 0, 6'b000000, 5'd3, 1, 32'hAAAA_AAAA, 1, 32'hDEAD_BEEF, 64'h0,                 2'd0, 5'd3, 1, 32'hAAAA_AAAA, 1, 32'hDEAD_BEEF, 64'h0,                 2'd0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 6'b011111, 5'd9, 0, 32'h0,        0, 32'h0,        64'h99,                2'd1, 5'd3, 1, 32'hAAAA_AAAA, 1, 32'hDEAD_BEEF, 64'h0,                 2'd0)); // hold
    vecs.push_back(mk(0, 0, 6'b001000, 5'd1, 1, 32'h5,        0, 32'h0,        64'h123,               2'd3, 5'd0, 0, 32'h0,        0, 32'h0,        64'h123,               2'd0)); // cnt 3 -> 0
    vecs.push_back(mk(0, 0, 6'b001000, 5'd1, 1, 32'h5,        0, 32'h0,        64'hABC,               2'd2, 5'd0, 0, 32'h0,        0, 32'h0,        64'hABC,               2'd0)); // cnt 2 -> 0
    vecs.push_back(mk(0, 0, 6'b001000, 5'd1, 1, 32'h5,        0, 32'h0,        64'hABC,               2'd1, 5'd0, 0, 32'h0,        0, 32'h0,        64'hABC,               2'd1));
    vecs.push_back(mk(0, 0, 6'b011111, 5'd2, 1, 32'h6,        1, 32'h7,        64'h0,                 2'd0, 5'd0, 0, 32'h0,        0, 32'h0,        64'hABC,               2'd1)); // hold acc
    vecs.push_back(mk(0, 1, 6'b001111, 5'd2, 1, 32'h6,        1, 32'h7,        64'h77,                2'd1, 5'd0, 0, 32'h0,        0, 32'h0,        64'h0,                 2'd0)); // flush over bubble
    vecs.push_back(mk(0, 0, 6'b001111, 5'd2, 1, 32'h6,        1, 32'h7,        64'h1_0000_0000,       2'd1, 5'd0, 0, 32'h0,        0, 32'h0,        64'h1_0000_0000,       2'd1));
    vecs.push_back(mk(1, 0, 6'b001111, 5'd2, 1, 32'h6,        1, 32'h7,        64'h1,                 2'd1, 5'd0, 0, 32'h0,        0, 32'h0,        64'h0,                 2'd0)); // rst mid-accumulate
    vecs.push_back(mk(0, 0, 6'b000000, 5'd4, 1, 32'h8,        1, 32'hDEAD_BEEF, 64'h0,                 2'd0, 5'd4, 1, 32'h8,        1, 32'hDEAD_BEEF, 64'h0,                 2'd0));
    vecs.push_back(mk(1, 0, 6'b011111, 5'd4, 1, 32'h8,        1, 32'hDEAD_BEEF, 64'h0,                 2'd0, 5'd0, 0, 32'h0,        0, 32'h0,        64'h0,                 2'd0)); // rst beats hold
    vecs.push_back(mk(0, 0, 6'b010000, 5'd31, 1, 32'hFFFF_FFFF, 0, 32'h0,       64'h3,                 2'd1, 5'd31, 1, 32'hFFFF_FFFF, 0, 32'h0,      64'h0,                 2'd0)); // stall 0/1 advances
    vecs.push_back(mk(0, 0, 6'b110111, 5'd30, 0, 32'h0BAD_F00D, 1, 32'h1,      64'h3,                 2'd1, 5'd30, 0, 32'h0BAD_F00D, 1, 32'h1,      64'h0,                 2'd0));
    vecs.push_back(mk(0, 0, 6'b001111, 5'd1, 1, 32'h1,        0, 32'h0,        64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 5'd0, 0, 32'h0,       0, 32'h0,        64'hFFFF_FFFF_FFFF_FFFF, 2'd1));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; flush = vecs[i].flush; stall = vecs[i].stall;
      ex_wd = vecs[i].wd; ex_wreg = vecs[i].wreg; ex_wdata = vecs[i].wdata;
      ex_whilo = vecs[i].whilo; ex_hi = vecs[i].hi;
      hilo_i = vecs[i].hilo; cnt_i = vecs[i].cnt;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.wd", i),    64'(mem_wd),    64'(vecs[i].exp_wd));
      chk($sformatf("vec%0d.wreg", i),  64'(mem_wreg),  64'(vecs[i].exp_wreg));
      chk($sformatf("vec%0d.wdata", i), 64'(mem_wdata), 64'(vecs[i].exp_wdata));
      chk($sformatf("vec%0d.whilo", i), 64'(mem_whilo), 64'(vecs[i].exp_whilo));
      chk($sformatf("vec%0d.hi", i),    64'(mem_hi),    64'(vecs[i].exp_hi));
      chk($sformatf("vec%0d.hilo", i),  hilo_o,         AccEn ? vecs[i].exp_hilo : 64'h0);
      chk($sformatf("vec%0d.cnt", i),   64'(cnt_o),     AccEn ? 64'(vecs[i].exp_cnt) : 64'h0);
    end

    // Reset pulse between edges must not disturb the registers
    rst = 1'b0; flush = 1'b0; stall = 6'b000000;
    ex_wd = 5'd12; ex_wreg = 1'b1; ex_wdata = 32'hC0DE_0012;
    ex_whilo = 1'b1; ex_hi = 32'h1357_9BDF;
    @(posedge clk); #1;
    stall = 6'b011111;
    rst = 1'b1; #2; rst = 1'b0; #1;
    chk("rstpulse.mid.wdata", 64'(mem_wdata), 64'h0000_0000_C0DE_0012);
    @(posedge clk); #1;
    chk("rstpulse.after.wd",    64'(mem_wd),    64'd12);
    chk("rstpulse.after.whilo", 64'(mem_whilo), 64'd1);
    chk("rstpulse.after.hi",    64'(mem_hi),    64'h0000_0000_1357_9BDF);

    // Randomized run against the behavioural model
    rst = 1'b1; flush = 1'b0; stall = '0;
    model_step();
    @(posedge clk); #1;
    check_all("rnd.reset");
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(39) == 0);
      flush       = ($urandom_range(19) == 0);
      stall       = 6'($urandom);
      ex_wd       = 5'($urandom);
      ex_wreg     = 1'($urandom);
      ex_wdata    = $urandom;
      ex_hi       = $urandom;
      ex_lo       = $urandom;
      ex_whilo    = 1'($urandom);
      ex_aluop    = 8'($urandom);
      ex_mem_addr = $urandom;
      ex_reg2     = $urandom;
      hilo_i      = {$urandom, $urandom};
      cnt_i       = 2'($urandom);
      model_step();
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
